// File: rtl/aes_128_decrypt.sv
// Iterative AES-128 decryptor: runs the forward key schedule to rk10, then
// performs one inverse round per cycle while unwinding the key schedule.
module aes_128_decrypt (
  input  logic         CLK,
  input  logic         rst,
  input  logic         Valid,
  input  logic [127:0] Key,
  input  logic [127:0] Cypher_txt,
  output logic [127:0] Plain_txt,
  output logic         Done,
  output logic         Busy
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;

  state_t       fsm_state;
  logic [3:0]   cnt;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] fwd_key;
  logic [127:0] inv_key;
  logic [127:0] sub_shift;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // NOTE: function locals are combinational temporaries, so blocking '=' is correct here.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Recover the previous round key: later words first, then the first word.
  function automatic logic [127:0] expand_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  // Byte n = row + 4*col sits at [127-8n -: 8]; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  assign fwd_key   = expand_fwd(key_reg, rcon(cnt));
  assign inv_key   = expand_inv(key_reg, rcon(cnt));
  assign sub_shift = inv_shift_sub(state_reg);
  assign Busy      = (fsm_state != IDLE);

  // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      fsm_state <= IDLE;
      cnt       <= 4'd0;
      state_reg <= '0;
      key_reg   <= '0;
      Plain_txt <= '0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (fsm_state)
        IDLE: if (Valid) begin
          key_reg   <= Key;
          state_reg <= Cypher_txt;
          cnt       <= 4'd1;
          fsm_state <= KEXP;
        end
        KEXP: begin
          key_reg <= fwd_key;
          if (cnt == 4'd10) begin
            state_reg <= state_reg ^ fwd_key;
            fsm_state <= ROUND;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          key_reg <= inv_key;
          if (cnt == 4'd1) begin
            Plain_txt <= sub_shift ^ inv_key;
            Done      <= 1'b1;
            fsm_state <= IDLE;
          end else begin
            state_reg <= inv_mix(sub_shift ^ inv_key);
            cnt       <= cnt - 4'd1;
          end
        end
        default: fsm_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_decrypt.sv
// Bench for aes_128_decrypt: known-answer vectors, protocol corner cases and
// random round-trips against a table-based AES-128 encryption model.
module tb_aes_128_decrypt;

  logic         CLK = 1'b0;
  logic         rst = 1'b1;
  logic         Valid = 1'b0;
  logic [127:0] Key = '0;
  logic [127:0] Cypher_txt = '0;
  logic [127:0] Plain_txt;
  logic         Done;
  logic         Busy;

  aes_128_decrypt dut (
    .CLK(CLK), .rst(rst), .Valid(Valid), .Key(Key), .Cypher_txt(Cypher_txt),
    .Plain_txt(Plain_txt), .Done(Done), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cycle = 0;
  logic [127:0] last_pt = '0;
  logic [7:0] sbox_t [256];

  always @(posedge CLK) cyc++;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_C = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] CT_C  = 128'hff0b844a0853bf7c6934ab4364148fb9;
  localparam logic [127:0] PT_C  = 128'h0123456789abcdeffedcba9876543210;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box table from brute-force field inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 1);
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [7:0]  st [4][4];
    logic [7:0]  tmp [4][4];
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = sbox_t[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            st[r][c] = gmul(tmp[r][c], 8'h02) ^ gmul(tmp[(r+1)%4][c], 8'h03)
                     ^ tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
          else
            st[r][c] = tmp[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          st[r][c] ^= w[4*rnd+c][31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        out[127-8*(4*c+r) -: 8] = st[r][c];
    return out;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge with
  // inputs scrambled so any late sampling of Key/Cypher_txt corrupts the result.
  task automatic start(input logic [127:0] k, input logic [127:0] ct);
    Valid = 1'b1;
    Key = k;
    Cypher_txt = ct;
    @(negedge CLK);
    Valid = 1'b0;
    Key = rand128();
    Cypher_txt = rand128();
  endtask

  // Returns at the negedge where Done is high; optionally injects Valid at E5/E15.
  task automatic wait_done(input string tag, input logic [127:0] exp_pt, input bit inject);
    int k = 0;
    bit busy_ok = 1'b1;
    bit hold_ok = 1'b1;
    while (Done !== 1'b1 && k < 40) begin
      if (Busy !== 1'b1) busy_ok = 1'b0;
      if (Plain_txt !== last_pt) hold_ok = 1'b0;
      if (inject && (k == 4 || k == 14)) begin
        Valid = 1'b1;
        Key = KEY_B;
        Cypher_txt = CT_B;
      end else begin
        Valid = 1'b0;
      end
      @(negedge CLK);
      k++;
    end
    Valid = 1'b0;
    check({tag, " latency"}, 128'(k), 128'd20);
    check({tag, " plain"}, Plain_txt, exp_pt);
    check({tag, " busy_in_done"}, 128'(Busy), 128'd0);
    check({tag, " busy_during"}, 128'(busy_ok), 128'd1);
    check({tag, " plain_hold"}, 128'(hold_ok), 128'd1);
    last_pt = exp_pt;
    done_cycle = cyc;
  endtask

  task automatic expect_done_drop(input string tag);
    @(negedge CLK);
    check({tag, " done_pulse"}, 128'(Done), 128'd0);
  endtask

  initial begin
    int first_done;
    bit quiet;
    logic [127:0] rk, rp;
    build_sbox();

    repeat (2) @(negedge CLK);
    check("reset plain", Plain_txt, 128'd0);
    check("reset done", 128'(Done), 128'd0);
    check("reset busy", 128'(Busy), 128'd0);
    rst = 1'b0;

    start(KEY_A, CT_A);  wait_done("vecA", PT_A, 1'b0); expect_done_drop("vecA");
    start(KEY_B, CT_B);  wait_done("vecB", PT_B, 1'b0); expect_done_drop("vecB");
    start(KEY_C, CT_C);  wait_done("vecC", PT_C, 1'b0); expect_done_drop("vecC");

    start(KEY_A, CT_A);  wait_done("ignore_valid", PT_A, 1'b1); expect_done_drop("ignore_valid");

    start(KEY_A, CT_A);  wait_done("b2b_first", PT_A, 1'b0);
    first_done = done_cycle;
    start(KEY_B, CT_B);  wait_done("b2b_second", PT_B, 1'b0);
    check("b2b spacing", 128'(done_cycle - first_done), 128'd21);
    expect_done_drop("b2b_second");

    start(KEY_B, CT_B);
    repeat (11) @(negedge CLK);
    rst = 1'b1;
    #1;
    check("abort plain", Plain_txt, 128'd0);
    check("abort done", 128'(Done), 128'd0);
    check("abort busy", 128'(Busy), 128'd0);
    quiet = 1'b1;
    repeat (12) begin
      @(negedge CLK);
      if (Done !== 1'b0 || Busy !== 1'b0) quiet = 1'b0;
      rst = 1'b0;
    end
    check("abort no_done", 128'(quiet), 128'd1);
    last_pt = '0;
    start(KEY_C, CT_C);  wait_done("after_abort", PT_C, 1'b0); expect_done_drop("after_abort");

    for (int i = 0; i < 8; i++) begin
      rk = rand128();
      rp = rand128();
      start(rk, aes_enc(rk, rp));
      wait_done($sformatf("rand%0d", i), rp, 1'b0);
      expect_done_drop($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
